// File: rtl/griffin_pkg.sv
// rtl/griffin_pkg.sv - shared types, constants and FSM encoding for the Griffin round sequencer
package griffin_pkg;

    localparam int FELEM_BITS  = 254;
    localparam int STATE_ELEMS = 3;

    // BN254 scalar field modulus, the default field for this permutation
    localparam logic [255:0] PRIME_MODULUS =
        256'h30644e72e131a029b85045b68181585d2833e84879b9709143e1f593f0000001;

    typedef logic [FELEM_BITS-1:0]           felem_t;
    typedef felem_t [STATE_ELEMS-1:0]        state_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE_AFF,
        S_NL_START,
        S_NL_WAIT,
        S_AFF,
        S_DONE
    } seq_state_e;

    // Control outputs are registered together with the state they belong to
    typedef struct packed {
        logic in_ready;
        logic out_valid;
        logic nl_start;
        logic rc_zero;
        logic busy;
    } seq_flags_t;

    function automatic seq_flags_t flags_for(seq_state_e s);
        seq_flags_t f;
        f           = '0;
        f.in_ready  = (s == S_IDLE);
        f.out_valid = (s == S_DONE);
        f.nl_start  = (s == S_NL_START);
        f.rc_zero   = (s == S_PRE_AFF);
        f.busy      = (s != S_IDLE);
        return f;
    endfunction

endpackage

// File: rtl/griffin_round_sequencer.sv
// rtl/griffin_round_sequencer.sv - sequences one Griffin permutation over external affine and nonlinear units
module griffin_round_sequencer
    import griffin_pkg::*;
#(
    parameter int N_BITS     = FELEM_BITS,
    parameter int STATE_SIZE = STATE_ELEMS,
    parameter int N_ROUNDS   = 14,
    parameter int AFF_LAT    = 1,
    localparam int RW        = (N_ROUNDS > 1) ? $clog2(N_ROUNDS) : 1,
    localparam int CW        = (AFF_LAT > 0) ? $clog2(AFF_LAT + 1) : 1
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [STATE_SIZE-1:0][N_BITS-1:0]    in_state,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [STATE_SIZE-1:0][N_BITS-1:0]    out_state,
    output logic                                 nl_start,
    output logic [STATE_SIZE-1:0][N_BITS-1:0]    nl_state,
    input  logic                                 nl_done,
    input  logic [STATE_SIZE-1:0][N_BITS-1:0]    nl_result,
    output logic [STATE_SIZE-1:0][N_BITS-1:0]    aff_state,
    input  logic [STATE_SIZE-1:0][N_BITS-1:0]    aff_result,
    output logic [RW-1:0]                        rc_addr,
    output logic                                 rc_zero,
    output logic [RW-1:0]                        round_idx,
    output logic                                 busy
);

    localparam logic [CW-1:0] AFF_LAST   = CW'(AFF_LAT);
    localparam logic [RW-1:0] ROUND_LAST = RW'(N_ROUNDS - 1);

    seq_state_e                          state;
    seq_flags_t                          flags;
    logic [STATE_SIZE-1:0][N_BITS-1:0]   work;
    logic [RW-1:0]                       round;
    logic [CW-1:0]                       aff_cnt;

    // The working register is the only operand source, so every consumer sees it directly
    assign out_state = work;
    assign nl_state  = work;
    assign aff_state = work;
    assign rc_addr   = round;
    assign round_idx = round;

    assign in_ready  = flags.in_ready;
    assign out_valid = flags.out_valid;
    assign nl_start  = flags.nl_start;
    assign rc_zero   = flags.rc_zero;
    assign busy      = flags.busy;

    // Permutation FSM: state, registered control flags, working register and counters
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            flags   <= '0;
            work    <= '0;
            round   <= '0;
            aff_cnt <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid && flags.in_ready) begin
                        work    <= in_state;
                        round   <= '0;
                        aff_cnt <= '0;
                        state   <= S_PRE_AFF;
                        flags   <= flags_for(S_PRE_AFF);
                    end else begin
                        // also raises in_ready on the first cycle after reset release
                        flags   <= flags_for(S_IDLE);
                    end
                end
                S_PRE_AFF, S_AFF: begin
                    // the affine window holds its operand for AFF_LAT+1 cycles, then takes the result
                    if (aff_cnt == AFF_LAST) begin
                        work    <= aff_result;
                        aff_cnt <= '0;
                        if (state == S_AFF && round == ROUND_LAST) begin
                            state <= S_DONE;
                            flags <= flags_for(S_DONE);
                        end else begin
                            if (state == S_AFF) begin
                                round <= round + 1'b1;
                            end
                            state <= S_NL_START;
                            flags <= flags_for(S_NL_START);
                        end
                    end else begin
                        aff_cnt <= aff_cnt + 1'b1;
                    end
                end
                S_NL_START: begin
                    state <= S_NL_WAIT;
                    flags <= flags_for(S_NL_WAIT);
                end
                S_NL_WAIT: begin
                    // nl_done only matters here, so stray pulses elsewhere cannot advance a round
                    if (nl_done) begin
                        work    <= nl_result;
                        aff_cnt <= '0;
                        state   <= S_AFF;
                        flags   <= flags_for(S_AFF);
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state <= S_IDLE;
                        flags <= flags_for(S_IDLE);
                    end
                end
                default: begin
                    state <= S_IDLE;
                    flags <= flags_for(S_IDLE);
                end
            endcase
        end
    end

endmodule

// File: tb/tb_griffin_round_sequencer.sv
// tb/tb_griffin_round_sequencer.sv - randomized self-checking bench for griffin_round_sequencer
module tb_griffin_round_sequencer;
    import griffin_pkg::*;

    localparam int NR = 14;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic       rst_n;
    logic       in_valid, in_ready, out_valid, out_ready;
    logic       nl_start, nl_done, rc_zero, busy;
    state_t     in_state, out_state, nl_state, nl_result, aff_state, aff_result;
    logic [3:0] rc_addr, round_idx;

    griffin_round_sequencer #(.N_ROUNDS(NR), .AFF_LAT(1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_state(in_state),
        .out_valid(out_valid), .out_ready(out_ready), .out_state(out_state),
        .nl_start(nl_start), .nl_state(nl_state), .nl_done(nl_done), .nl_result(nl_result),
        .aff_state(aff_state), .aff_result(aff_result), .rc_addr(rc_addr), .rc_zero(rc_zero),
        .round_idx(round_idx), .busy(busy)
    );

    // Secondary instances for the parameter sweep (single round, AFF_LAT 2 and 0)
    logic       in_valid_s, out_ready_s;
    state_t     in_state_s;
    logic       in_ready2, out_valid2, nl_start2, nl_done2, rc_zero2, busy2;
    state_t     out_state2, nl_state2, aff_state2, aff_result2, a2_q1;
    logic [0:0] rc_addr2, round_idx2;
    logic       in_ready3, out_valid3, nl_start3, nl_done3, rc_zero3, busy3;
    state_t     out_state3, nl_state3, aff_state3, aff_result3;
    logic [0:0] rc_addr3, round_idx3;

    griffin_round_sequencer #(.N_ROUNDS(1), .AFF_LAT(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_s), .in_ready(in_ready2), .in_state(in_state_s),
        .out_valid(out_valid2), .out_ready(out_ready_s), .out_state(out_state2),
        .nl_start(nl_start2), .nl_state(nl_state2), .nl_done(nl_done2), .nl_result(nl_fn(nl_state2)),
        .aff_state(aff_state2), .aff_result(aff_result2), .rc_addr(rc_addr2), .rc_zero(rc_zero2),
        .round_idx(round_idx2), .busy(busy2)
    );

    griffin_round_sequencer #(.N_ROUNDS(1), .AFF_LAT(0)) dut3 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_s), .in_ready(in_ready3), .in_state(in_state_s),
        .out_valid(out_valid3), .out_ready(out_ready_s), .out_state(out_state3),
        .nl_start(nl_start3), .nl_state(nl_state3), .nl_done(nl_done3), .nl_result(nl_fn(nl_state3)),
        .aff_state(aff_state3), .aff_result(aff_result3), .rc_addr(rc_addr3), .rc_zero(rc_zero3),
        .round_idx(round_idx3), .busy(busy3)
    );

    // ---------------- reference functions ----------------
    state_t rc_rom [NR];

    function automatic felem_t rand_fe();
        felem_t f = '0;
        for (int i = 0; i < 8; i++) f = {f[FELEM_BITS-33:0], 32'($urandom)};
        return f;
    endfunction

    function automatic state_t aff_fn(state_t s, state_t rc);
        state_t o;
        felem_t t = s[0] + s[1] + s[2];
        for (int i = 0; i < STATE_ELEMS; i++) o[i] = t + s[i] + rc[i];
        return o;
    endfunction

    function automatic state_t nl_fn(state_t s);
        state_t y;
        y[0] = s[0] * s[0] * s[0];
        y[1] = s[1] * (s[0] + felem_t'(1)) + s[2];
        y[2] = s[2] ^ (s[1] << 3);
        return y;
    endfunction

    function automatic state_t ref_perm(state_t s, int nr, bit use_rc);
        state_t x = aff_fn(s, '0);
        for (int r = 0; r < nr; r++) begin
            x = nl_fn(x);
            x = aff_fn(x, use_rc ? rc_rom[r] : '0);
        end
        return x;
    endfunction

    // ---------------- external unit models ----------------
    // Affine unit, one register stage, round constants muxed to zero on rc_zero
    always @(posedge clk) aff_result <= aff_fn(aff_state, rc_zero ? '0 : rc_rom[rc_addr]);
    always @(posedge clk) begin
        a2_q1       <= aff_fn(aff_state2, '0);
        aff_result2 <= a2_q1;
    end
    assign aff_result3 = aff_fn(aff_state3, '0);
    always @(posedge clk) begin
        nl_done2 <= rst_n && nl_start2;
        nl_done3 <= rst_n && nl_start3;
    end

    // Nonlinear unit: answers k cycles after the start pulse, k fixed at 1 or random 1..7
    int     nl_cnt = 0;
    int     nl_pulses = 0;
    int     rc_log[$];
    state_t nl_hold;
    bit     rand_k = 1'b0;
    bit     spur_en = 1'b0;
    logic   spur = 1'b0;
    always @(posedge clk) begin
        if (!rst_n) begin
            nl_cnt <= 0;
        end else if (nl_start) begin
            nl_cnt    <= rand_k ? int'($urandom_range(1, 7)) : 1;
            nl_hold   <= nl_state;
            nl_pulses <= nl_pulses + 1;
            rc_log.push_back(int'(rc_addr));
        end else if (nl_cnt > 0) begin
            nl_cnt <= nl_cnt - 1;
        end
    end
    assign nl_done   = (nl_cnt == 1) || spur;
    assign nl_result = nl_fn(nl_hold);

    // Stray nl_done pulses while the sequencer sits in an affine window (PRE_AFF or AFF)
    always @(negedge clk)
        spur = spur_en && busy && !out_valid && !nl_start && (rc_zero || nl_cnt == 0);

    // ---------------- checking ----------------
    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [767:0] got, input logic [767:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One permutation: accept, wait for result, optionally hold out_ready low for bp cycles
    task automatic run(input state_t s, input int bp, output int lat, output state_t res);
        int acc, t;
        in_state = s;
        in_valid = 1'b1;
        t = 0;
        while (!in_ready && t < 400) begin @(negedge clk); t++; end
        chk("accept_timeout", in_ready, 1'b1);
        acc = cyc + 1;
        @(negedge clk);
        if (bp == 0) in_valid = 1'b0;
        t = 0;
        while (!out_valid && t < 400) begin @(negedge clk); t++; end
        chk("result_timeout", out_valid, 1'b1);
        lat = cyc - acc;
        res = out_state;
        for (int i = 0; i < bp; i++) begin
            @(negedge clk);
            chk("bp_state_stable", out_state, res);
            chk("bp_in_ready_low", in_ready, 1'b0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        if (bp > 0) chk("in_ready_after_handshake", in_ready, 1'b1);
    endtask

    state_t g, s, res, golden;
    int     lat, p0, l0, t, acc, lat2, lat3;

    initial begin
        for (int r = 0; r < NR; r++) rc_rom[r] = {rand_fe(), rand_fe(), rand_fe()};
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_state = '0;
        in_valid_s = 1'b0; out_ready_s = 1'b0; in_state_s = '0;
        repeat (3) @(negedge clk);

        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_nl_start", nl_start, 1'b0);
        chk("rst_rc_zero", rc_zero, 1'b0);
        chk("rst_round_idx", round_idx, 4'd0);
        chk("rst_rc_addr", rc_addr, 4'd0);
        chk("rst_out_state", out_state, '0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_in_ready", in_ready, 1'b1);
        chk("idle_busy", busy, 1'b0);

        // Golden vector, fixed k=1
        g[0] = felem_t'(0); g[1] = felem_t'(1); g[2] = felem_t'(2);
        golden = ref_perm(g, NR, 1'b1);
        p0 = nl_pulses; l0 = rc_log.size();
        run(g, 0, lat, res);
        chk("golden_latency", lat, 58);
        chk("golden_result", res, golden);
        chk("golden_nl_pulses", nl_pulses - p0, NR);

        // Variable nonlinear latency
        rand_k = 1'b1;
        p0 = nl_pulses; l0 = rc_log.size();
        run(g, 0, lat, res);
        chk("vark_result", res, golden);
        chk("vark_nl_pulses", nl_pulses - p0, NR);
        chk("vark_rc_log_len", rc_log.size() - l0, NR);
        for (int r = 0; r < NR && l0 + r < rc_log.size(); r++) chk("vark_rc_addr_step", rc_log[l0 + r], r);

        // Random states
        repeat (3) begin
            s = {rand_fe(), rand_fe(), rand_fe()};
            run(s, 0, lat, res);
            chk("random_result", res, ref_perm(s, NR, 1'b1));
        end

        // Spurious nl_done in affine windows
        spur_en = 1'b1;
        p0 = nl_pulses;
        s = {rand_fe(), rand_fe(), rand_fe()};
        run(s, 0, lat, res);
        spur_en = 1'b0;
        chk("spur_result", res, ref_perm(s, NR, 1'b1));
        chk("spur_nl_pulses", nl_pulses - p0, NR);

        // Back-pressure, then a second state queued behind it
        s = {rand_fe(), rand_fe(), rand_fe()};
        run(s, 20, lat, res);
        chk("bp_result", res, ref_perm(s, NR, 1'b1));
        s = {rand_fe(), rand_fe(), rand_fe()};
        p0 = cyc;
        run(s, 0, lat, res);
        chk("bp_second_result", res, ref_perm(s, NR, 1'b1));

        // Reset in round 5, then rerun
        s = {rand_fe(), rand_fe(), rand_fe()};
        in_state = s; in_valid = 1'b1;
        t = 0;
        while (!in_ready && t < 400) begin @(negedge clk); t++; end
        @(negedge clk);
        in_valid = 1'b0;
        t = 0;
        while (round_idx != 4'd5 && t < 400) begin @(negedge clk); t++; end
        chk("reach_round5", round_idx, 4'd5);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_out_valid", out_valid, 1'b0);
        chk("midrst_round_idx", round_idx, 4'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_in_ready", in_ready, 1'b1);
        chk("midrst_busy_after", busy, 1'b0);
        p0 = nl_pulses;
        repeat (10) @(negedge clk);
        chk("midrst_no_stale_start", nl_pulses - p0, 0);
        run(s, 0, lat, res);
        chk("midrst_rerun_result", res, ref_perm(s, NR, 1'b1));

        // Parameter sweep: N_ROUNDS=1 with AFF_LAT=2 and AFF_LAT=0, k=1
        s = {rand_fe(), rand_fe(), rand_fe()};
        in_state_s = s; in_valid_s = 1'b1;
        t = 0;
        while (!(in_ready2 && in_ready3) && t < 50) begin @(negedge clk); t++; end
        acc = cyc + 1;
        @(negedge clk);
        in_valid_s = 1'b0;
        lat2 = -1; lat3 = -1;
        for (int i = 0; i < 40; i++) begin
            if (out_valid2 && lat2 < 0) lat2 = cyc - acc;
            if (out_valid3 && lat3 < 0) lat3 = cyc - acc;
            @(negedge clk);
        end
        chk("sweep_lat_afflat2", lat2, 8);
        chk("sweep_lat_afflat0", lat3, 4);
        chk("sweep_result_afflat2", out_state2, ref_perm(s, 1, 1'b0));
        chk("sweep_result_afflat0", out_state3, ref_perm(s, 1, 1'b0));
        out_ready_s = 1'b1;
        @(negedge clk);
        out_ready_s = 1'b0;
        chk("sweep_idle_afflat2", in_ready2, 1'b1);
        chk("sweep_idle_afflat0", in_ready3, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
